// File: rtl/bb_ram_param.sv
// bb_ram_param: single-port byte-lane RAM, zero sweep after reset/clear.
// Read latency of 1 or 2 cycles; optional lane parity under BB_RAM_PARITY_EN.
//
// Parameters:
//   DATA_W   word width, multiple of 8 (8..128)
//   ADDR_W   word address width, depth is 2**ADDR_W words
//   READ_LAT read latency in cycles, 1 or 2
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   en       access request this cycle
//   we       per-byte-lane write enable; all zero means read
//   addr     word address
//   data_in  write data
//   clear    pulse that starts a full zero sweep
//   data_out read data, held between reads
//   rvalid   one-cycle pulse per completed read
//   busy     zero sweep in progress, accesses ignored
//   par_err  lane parity mismatch on the current rvalid beat
// Macro:
//   BB_RAM_PARITY_EN  adds one even-parity bit per lane and the read check

module bb_ram_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                clear,
    output logic [DATA_W-1:0]   data_out,
    output logic                rvalid,
    output logic                busy,
    output logic                par_err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  cnt;

    logic               in_init;
    logic               in_run;
    logic               run_acc;
    logic               rd;
    logic [NB-1:0]      wr_lanes;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [DATA_W-1:0]  s1_data;
    logic               s1_v;
    logic               s1_bad;

    // A reset cycle performs no memory access; it only redirects control.
    assign in_init  = reset && (state == INIT);
    assign in_run   = reset && (state == RUN);
    assign run_acc  = in_run && en;
    assign rd       = run_acc && (we == '0);

    // The sweep borrows the single write port, all lanes, data zero.
    assign wr_lanes = in_init ? '1 : (run_acc ? we : '0);
    assign wr_addr  = in_init ? cnt : addr;
    assign wr_data  = in_init ? '0 : data_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {ADDR_W{1'b1}}) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state <= INIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lanes[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_v <= rd;
            if (rd) begin
                s1_data <= mem[addr];
            end
        end
    end

`ifdef BB_RAM_PARITY_EN
    logic [NB-1:0] pmem [DEPTH];
    logic [NB-1:0] s1_par;
    logic [NB-1:0] lane_bad;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lanes[i]) begin
                pmem[wr_addr][i] <= ^wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_par <= '0;
        end else if (rd) begin
            s1_par <= pmem[addr];
        end
    end

    // Even parity: stored bit equals the XOR of the lane's data bits.
    always_comb begin
        lane_bad = '0;
        for (int i = 0; i < NB; i++) begin
            lane_bad[i] = (^s1_data[8*i +: 8]) != s1_par[i];
        end
    end

    assign s1_bad = s1_v && (|lane_bad);
`else
    assign s1_bad = 1'b0;
`endif

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_v;
            logic              s2_bad;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    s2_v    <= 1'b0;
                    s2_bad  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_v   <= s1_v;
                    s2_bad <= s1_bad;
                    if (s1_v) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign data_out = s2_data;
            assign rvalid   = s2_v;
            assign par_err  = s2_bad;
        end else begin : g_lat1
            assign data_out = s1_data;
            assign rvalid   = s1_v;
            assign par_err  = s1_bad;
        end
    endgenerate

endmodule

// File: tb/tb_bb_ram_param.sv
// tb_bb_ram_param: drives a READ_LAT=1 and a READ_LAT=2 instance together
// and checks both against an issue-time/latency reference model.

module tb_bb_ram_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          en;
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          clear;

    logic [DW-1:0] d1, d2;
    logic          v1, v2, b1, b2, p1, p2;

    bb_ram_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr),
        .data_in(data_in), .clear(clear), .data_out(d1), .rvalid(v1),
        .busy(b1), .par_err(p1)
    );

    bb_ram_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr),
        .data_in(data_in), .clear(clear), .data_out(d2), .rvalid(v2),
        .busy(b2), .par_err(p2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: memory contents, sweep progress, and a history of
    // read issues; an output for latency L is the issue L-1 edges back.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_init = 1'b1;
    int            m_cnt  = 0;
    bit            hv [1024];
    logic [DW-1:0] hd [1024];
    int            n = 4;
    bit            ev [1:2];
    logic [DW-1:0] ed [1:2];
    bit            eb = 1'b1;

    task automatic model_edge();
        bit            rd;
        bit            flush;
        logic [DW-1:0] rdat;
        rd    = 1'b0;
        flush = 1'b0;
        rdat  = '0;
        n++;
        if (!reset) begin
            m_init = 1'b1;
            m_cnt  = 0;
            flush  = 1'b1;
        end else if (m_init) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_init = 1'b0;
        end else begin
            if (en) begin
                if (we == '0) begin
                    rd   = 1'b1;
                    rdat = m_mem[addr];
                end else begin
                    for (int i = 0; i < NB; i++)
                        if (we[i]) m_mem[addr][8*i +: 8] = data_in[8*i +: 8];
                end
            end
            if (clear) begin
                m_init = 1'b1;
                m_cnt  = 0;
            end
        end
        hv[n % 1024] = rd;
        hd[n % 1024] = rdat;
        if (flush) hv[(n - 1) % 1024] = 1'b0;
        for (int l = 1; l <= 2; l++) begin
            int k;
            k = (n - l + 1) % 1024;
            if (flush) begin
                ev[l] = 1'b0;
                ed[l] = '0;
            end else begin
                ev[l] = hv[k];
                if (hv[k]) ed[l] = hd[k];
            end
        end
        eb = m_init;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit e, input logic [NB-1:0] w,
                         input logic [AW-1:0] a, input logic [DW-1:0] dat,
                         input bit c);
        en      = e;
        we      = w;
        addr    = a;
        data_in = dat;
        clear   = c;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        tick();
        tick();
        tests++;
        if ({d1, v1, b1, p1} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_lat1: got d=%h v=%b b=%b p=%b expected d=0 v=0 b=1 p=0",
                     d1, v1, b1, p1);
        end
        tests++;
        if ({d2, v2, b2, p2} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_lat2: got d=%h v=%b b=%b p=%b expected d=0 v=0 b=1 p=0",
                     d2, v2, b2, p2);
        end
    endtask

    task automatic test_sweep();
        int c1, c2;
        c1 = 0;
        c2 = 0;
        reset = 1'b1;
        for (int i = 0; i < 40 && (b1 || b2); i++) begin
            if (b1) c1++;
            if (b2) c2++;
            tick();
        end
        tests++;
        if (c1 !== DEPTH || c2 !== DEPTH) begin
            fails++;
            $display("FAIL sweep_busy_len: got %0d/%0d expected %0d", c1, c2, DEPTH);
        end
        for (int a = 0; a <= DEPTH; a++) begin
            if (a < DEPTH) drive(1'b1, '0, AW'(a), '0, 1'b0);
            else drive(1'b0, '0, '0, '0, 1'b0);
            tick();
            tests++;
            if (v1 !== ev[1] || d1 !== ed[1] || v2 !== ev[2] || d2 !== ed[2]
                || (v1 && d1 !== '0) || (v2 && d2 !== '0)) begin
                fails++;
                $display("FAIL sweep_read_zero a=%0d: got %b/%h %b/%h expected %b/%h %b/%h",
                         a, v1, d1, v2, d2, ev[1], ed[1], ev[2], ed[2]);
            end
        end
    endtask

    task automatic test_merge();
        drive(1'b1, 4'hF, 4'd5, 32'hA1B2C3D4, 1'b0);
        tick();
        drive(1'b1, 4'b0010, 4'd5, 32'h0000EE00, 1'b0);
        tick();
        drive(1'b1, 4'h0, 4'd5, DW'($urandom), 1'b0);
        tick();
        tests++;
        if (v1 !== 1'b1 || d1 !== 32'hA1B2EED4 || v2 !== 1'b0) begin
            fails++;
            $display("FAIL merge_lat1: got v1=%b d1=%h v2=%b expected 1 a1b2eed4 0",
                     v1, d1, v2);
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        tick();
        tests++;
        if (v1 !== 1'b0 || d1 !== 32'hA1B2EED4 || v2 !== 1'b1
            || d2 !== 32'hA1B2EED4) begin
            fails++;
            $display("FAIL merge_lat2: got v1=%b d1=%h v2=%b d2=%h expected 0 a1b2eed4 1 a1b2eed4",
                     v1, d1, v2, d2);
        end
        tick();
        tests++;
        if (v2 !== 1'b0 || d2 !== 32'hA1B2EED4) begin
            fails++;
            $display("FAIL merge_hold: got v2=%b d2=%h expected 0 a1b2eed4", v2, d2);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] x [3];
        for (int i = 0; i < 3; i++) begin
            x[i] = DW'($urandom);
            drive(1'b1, 4'hF, AW'(i), x[i], 1'b0);
            tick();
        end
        for (int t = 0; t < 5; t++) begin
            bit xv1, xv2;
            if (t < 3) drive(1'b1, '0, AW'(t), '0, 1'b0);
            else drive(1'b0, '0, '0, '0, 1'b0);
            tick();
            xv1 = (t < 3);
            xv2 = (t >= 1 && t <= 3);
            tests++;
            if (v1 !== xv1 || v2 !== xv2 || (xv1 && d1 !== x[t])
                || (xv2 && d2 !== x[t-1])) begin
                fails++;
                $display("FAIL back_to_back t=%0d: got %b/%h %b/%h expected v %b %b",
                         t, v1, d1, v2, d2, xv1, xv2);
            end
        end
    endtask

    task automatic test_clear();
        logic [DW-1:0] x;
        int c;
        x = DW'($urandom) | 32'h1;
        drive(1'b1, 4'hF, 4'd9, x, 1'b0);
        tick();
        drive(1'b1, '0, 4'd9, '0, 1'b0);
        tick();
        tests++;
        if (v1 !== 1'b1 || d1 !== x) begin
            fails++;
            $display("FAIL clear_pre_read: got %b/%h expected 1/%h", v1, d1, x);
        end
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        tests++;
        if (v2 !== 1'b1 || d2 !== x || v1 !== 1'b0) begin
            fails++;
            $display("FAIL clear_inflight: got v2=%b d2=%h v1=%b expected 1 %h 0",
                     v2, d2, v1, x);
        end
        c = 0;
        for (int i = 0; i < 40 && b1; i++) begin
            c++;
            drive(1'b1, 4'($urandom_range(1, 0) * $urandom), AW'($urandom),
                  DW'($urandom), 1'($urandom));
            tick();
            tests++;
            if ((b1 && (v1 !== 1'b0 || v2 !== 1'b0)) || b2 !== b1) begin
                fails++;
                $display("FAIL clear_ignored i=%0d: got v1=%b v2=%b b2=%b expected 0 0 %b",
                         i, v1, v2, b2, b1);
            end
        end
        tests++;
        if (c !== DEPTH) begin
            fails++;
            $display("FAIL clear_busy_len: got %0d expected %0d", c, DEPTH);
        end
        for (int a = 0; a <= DEPTH; a++) begin
            if (a < DEPTH) drive(1'b1, '0, AW'(a), '0, 1'b0);
            else drive(1'b0, '0, '0, '0, 1'b0);
            tick();
            tests++;
            if ((v1 && d1 !== '0) || (v2 && d2 !== '0) || v1 !== ev[1]
                || v2 !== ev[2]) begin
                fails++;
                $display("FAIL clear_read_zero a=%0d: got %b/%h %b/%h expected zero data",
                         a, v1, d1, v2, d2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        drive(1'b1, '0, 4'd3, '0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        tick();
        tests++;
        if (v2 !== 1'b0 || d2 !== '0 || v1 !== 1'b0 || d1 !== '0 || b1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_midread: got v1=%b d1=%h v2=%b d2=%h b=%b expected 0 0 0 0 1",
                     v1, d1, v2, d2, b1);
        end
        reset = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if (b1 !== 1'b1 || b2 !== 1'b1) begin
            fails++;
            $display("FAIL reset_midsweep_busy: got %b/%b expected 1/1", b1, b2);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        c = 0;
        for (int i = 0; i < 40 && b1; i++) begin
            c++;
            tick();
        end
        tests++;
        if (c !== DEPTH || b2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_midsweep_len: got %0d b2=%b expected %0d 0", c, b2, DEPTH);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [NB-1:0] w;
            w = ($urandom_range(1, 0) == 0) ? '0 : NB'($urandom);
            drive($urandom_range(3, 0) != 0, w, AW'($urandom), DW'($urandom),
                  $urandom_range(99, 0) == 0);
            tick();
            tests++;
            if (v1 !== ev[1] || d1 !== ed[1] || b1 !== eb || p1 !== 1'b0) begin
                fails++;
                $display("FAIL random_lat1 i=%0d: got v=%b d=%h b=%b p=%b expected %b %h %b 0",
                         i, v1, d1, b1, p1, ev[1], ed[1], eb);
            end
            tests++;
            if (v2 !== ev[2] || d2 !== ed[2] || b2 !== eb || p2 !== 1'b0) begin
                fails++;
                $display("FAIL random_lat2 i=%0d: got v=%b d=%h b=%b p=%b expected %b %h %b 0",
                         i, v2, d2, b2, p2, ev[2], ed[2], eb);
            end
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 40 && b1; i++) tick();
    endtask

`ifdef BB_RAM_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 4'hF, 4'd3, 32'h000000FF, 1'b0);
        tick();
        drive(1'b1, 4'hF, 4'd4, 32'h000000FF, 1'b0);
        tick();
        u_lat1.mem[3][0] = ~u_lat1.mem[3][0];
        u_lat2.mem[3][0] = ~u_lat2.mem[3][0];
        m_mem[3][0] = ~m_mem[3][0];
        drive(1'b1, '0, 4'd3, '0, 1'b0);
        tick();
        tests++;
        if (v1 !== 1'b1 || p1 !== 1'b1 || d1 !== 32'h000000FE) begin
            fails++;
            $display("FAIL parity_flip_lat1: got v=%b p=%b d=%h expected 1 1 000000fe",
                     v1, p1, d1);
        end
        drive(1'b1, '0, 4'd4, '0, 1'b0);
        tick();
        tests++;
        if (v2 !== 1'b1 || p2 !== 1'b1 || v1 !== 1'b1 || p1 !== 1'b0) begin
            fails++;
            $display("FAIL parity_mixed: got v2=%b p2=%b v1=%b p1=%b expected 1 1 1 0",
                     v2, p2, v1, p1);
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        tick();
        tests++;
        if (v2 !== 1'b1 || p2 !== 1'b0 || p1 !== 1'b0) begin
            fails++;
            $display("FAIL parity_clean_lat2: got v2=%b p2=%b p1=%b expected 1 0 0",
                     v2, p2, p1);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        test_reset();
        test_sweep();
        test_merge();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
`ifdef BB_RAM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bb_ram_param.md
BB_RAM_PARAM -- requirements
Module: bb_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; a multiple of 8, range 8..128.
REQ-002 SHALL have parameter ADDR_W, default 11, word-address width (depth 2^ADDR_W words; the default gives 8192 bytes).
REQ-003 SHALL have parameter READ_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 reset  input  1  reset; synchronous, active-low.
REQ-006 en  input  1  access request for the current cycle.
REQ-007 we  input  DATA_W/8  per-byte-lane write enable; lane i is data bits [8i+7:8i].
REQ-008 addr  input  ADDR_W  word address.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 clear  input  1  single-cycle pulse that starts a full-memory zero sweep.
REQ-011 data_out  output  DATA_W  read data.
REQ-012 rvalid  output  1  data_out holds the result of a read in this cycle.
REQ-013 busy  output  1  zero sweep in progress; accesses are ignored.
REQ-014 par_err  output  1  parity mismatch on the current rvalid beat.

Function
REQ-015 SHALL implement the FSM states INIT and RUN, with INIT entered on reset.
REQ-016 In INIT, SHALL write zero to word cnt each cycle, with cnt counting from 0, and SHALL assert busy.
REQ-017 In INIT, when cnt = 2^ADDR_W-1, SHALL write that word and go to RUN on the next cycle.
REQ-018 In RUN, clear=1 SHALL cause a move to INIT with cnt=0 on the next cycle, and any in-flight read SHALL still complete.
REQ-019 In INIT, en, we and clear SHALL be ignored and no rvalid SHALL be generated for those cycles.
REQ-020 In RUN, en=1 with we=0 SHALL be a read, with data_out and rvalid asserted exactly READ_LAT cycles later.
REQ-021 In RUN, en=1 with we!=0 SHALL write only the enabled lanes; other lanes SHALL be unchanged and no rvalid SHALL be produced.
REQ-022 A read in the cycle after a write to the same address SHALL return the newly written lanes merged with the old lanes.
REQ-023 en=0 SHALL produce no access, and data_out SHALL hold its last value.
REQ-024 rvalid SHALL be a one-cycle pulse per read; back-to-back reads SHALL produce back-to-back pulses in issue order.
REQ-025 With READ_LAT=2, the RAM output SHALL be registered once more and rvalid delayed to match.
REQ-026 The access address SHALL not wrap; all 2^ADDR_W addresses SHALL be valid.
REQ-027 clear asserted in the same cycle as en in RUN SHALL perform that access, then enter INIT.

Reset
REQ-028 reset=0 sampled at a clock edge SHALL force state INIT, cnt=0, data_out=0, rvalid=0, busy=1 and par_err=0.
REQ-029 Reset asserted mid-sweep or mid-read SHALL flush the read pipeline and restart the sweep from word 0.
REQ-030 Memory contents SHALL not be reset directly; they SHALL be zeroed by the INIT sweep.

Configuration
REQ-031 With macro BB_RAM_PARITY_EN defined, SHALL store one even-parity bit per byte lane, written with its lane.
REQ-032 With BB_RAM_PARITY_EN defined, SHALL check each lane's parity on read and assert par_err with rvalid if any lane mismatches.
REQ-033 Without BB_RAM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be constant 0.

Verification
REQ-034 Release reset with ADDR_W=4 -> busy=1 for exactly 16 cycles, then 0; reads of all 16 words return 0.
REQ-035 Write addr 5, data_in=32'hA1B2C3D4, we=4'b1111; then write we=4'b0010, data_in=32'h0000EE00; read addr 5 -> data_out=32'hA1B2EED4, with rvalid exactly READ_LAT cycles after the read, for both READ_LAT=1 and READ_LAT=2.
REQ-036 Reads of addr 0,1,2 on consecutive cycles -> three consecutive rvalid pulses with data in order.
REQ-037 Pulse clear with a read in flight -> that read's rvalid is still produced; the next 2^ADDR_W cycles have busy=1; en is ignored; all words then read 0.
REQ-038 Assert reset at sweep cnt=7 -> after release the sweep restarts at 0 and busy lasts the full 2^ADDR_W cycles.
REQ-039 With BB_RAM_PARITY_EN defined, write 32'hFF, force bit 0 of the stored word to flip, read -> par_err=1 with rvalid; an unflipped word gives par_err=0.
